input_debouncer4: RTL and testbench

Input conditioning stage that sits directly upstream of the 4-bit flip_flop register and drives its d input. Raw asynchronous switch/button inputs pass through a two-stage synchronizer. Each bit is then debounced with a stability counter. The block presents a clean registered 4-bit value plus per-bit rise/fall strobes and an any-change strobe, which the downstream register uses as a load/set qualifier.

---
 rtl/input_debouncer4.sv | 86 ++++++++
 tb/tb_input_debouncer4.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer4.sv
// rtl/input_debouncer4.sv - two-stage synchronizer plus per-bit stability-counter debouncer with edge strobes
module input_debouncer4 #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             tick,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Terminal count: the edge that sees the counter here with tick high is
    // the STABLE_CYCLES-th qualifying sample, so that edge commits the bit.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state: synchronizer shift, per-bit qualification counters, strobes
    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                // Input agrees with the output again: drop any partial count
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i]  = sync2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign q       = deb_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_input_debouncer4.sv
// tb/tb_input_debouncer4.sv - directed stimulus with a per-cycle reference model for input_debouncer4
module tb_input_debouncer4;

    localparam int W  = 4;
    localparam int SC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d_in;
    logic         tick;
    logic [W-1:0] q, rise, fall;
    logic         changed;

    int tests = 0;
    int fails = 0;

    input_debouncer4 #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_in),
        .tick    (tick),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Reference model: input seen through a two-sample delay; each bit counts
    // tick-high samples of an uninterrupted disagreement and commits on the SC-th.
    logic [W-1:0] m_dly [2];
    logic [W-1:0] m_q, m_r, m_f;
    logic         m_c;
    int           m_run [W];
    bit           m_valid = 0;

    always @(posedge clk) begin
        logic [W-1:0] nq;
        if (reset) begin
            m_dly[0] = '0;
            m_dly[1] = '0;
            m_q = '0; m_r = '0; m_f = '0; m_c = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_valid = 1;
        end else begin
            nq = m_q;
            for (int i = 0; i < W; i++) begin
                if (m_dly[1][i] == m_q[i]) begin
                    m_run[i] = 0;
                end else if (tick) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == SC) begin
                        nq[i] = m_dly[1][i];
                        m_run[i] = 0;
                    end
                end
            end
            m_r = nq & ~m_q;
            m_f = m_q & ~nq;
            m_c = (m_r | m_f) != '0;
            m_q = nq;
            m_dly[1] = m_dly[0];
            m_dly[0] = d_in;
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if ({q, rise, fall, changed} !== {m_q, m_r, m_f, m_c}) begin
                fails++;
                $display("FAIL model t=%0t q/rise/fall/chg got %b/%b/%b/%b want %b/%b/%b/%b",
                         $time, q, rise, fall, changed, m_q, m_r, m_f, m_c);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %b want %b", name, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        d_in  = 4'b1111;
        tick  = 1'b1;

        // 1: reset holds everything at zero, then full latency to 1111
        edges(2);
        check("rst_q", q, 4'b0000);
        check("rst_rise", rise, 4'b0000);
        check("rst_fall", fall, 4'b0000);
        check("rst_chg", {3'b0, changed}, 4'b0000);
        @(negedge clk); reset = 1'b0;
        edges(9);
        check("t1_q_e9", q, 4'b0000);
        edges(1);
        check("t1_q_e10", q, 4'b1111);
        check("t1_rise", rise, 4'b1111);
        check("t1_chg", {3'b0, changed}, 4'b0001);
        edges(1);
        check("t1_chg_off", {3'b0, changed}, 4'b0000);

        // bring q back to zero, then 2: clean single-bit step
        @(negedge clk); d_in = 4'b0000;
        edges(12);
        check("t2_pre_q", q, 4'b0000);
        @(negedge clk); d_in = 4'b0001;
        edges(9);
        check("t2_q_e9", q, 4'b0000);
        edges(1);
        check("t2_q_e10", q, 4'b0001);
        check("t2_rise", rise, 4'b0001);
        check("t2_fall", fall, 4'b0000);
        check("t2_chg", {3'b0, changed}, 4'b0001);
        edges(1);
        check("t2_rise_off", rise, 4'b0000);

        // 3: five-cycle glitch on bit 1 is rejected
        @(negedge clk); d_in = 4'b0011;
        edges(5);
        @(negedge clk); d_in = 4'b0001;
        edges(12);
        check("t3_q", q, 4'b0001);

        // 4: simultaneous swap 0001 -> 1000
        @(negedge clk); d_in = 4'b1000;
        edges(9);
        check("t4_q_e9", q, 4'b0001);
        edges(1);
        check("t4_q_e10", q, 4'b1000);
        check("t4_rise", rise, 4'b1000);
        check("t4_fall", fall, 4'b0001);
        check("t4_chg", {3'b0, changed}, 4'b0001);
        edges(1);
        check("t4_chg_off", {3'b0, changed}, 4'b0000);

        // 5: tick high on odd edges only; eighth counted edge is edge 17
        @(negedge clk); d_in = 4'b0100;
        for (int e = 1; e <= 17; e++) begin
            tick = (e % 2) == 1;
            @(posedge clk); #1;
            if (e == 16) check("t5_q_e16", q, 4'b1000);
        end
        check("t5_q_e17", q, 4'b0100);
        check("t5_rise", rise, 4'b0100);
        check("t5_fall", fall, 4'b1000);
        tick = 1'b1;
        edges(2);

        // 6: reset after five counted edges, then full latency again
        @(negedge clk); d_in = 4'b0110;
        edges(7);
        check("t6_q_mid", q, 4'b0100);
        @(negedge clk); reset = 1'b1;
        edges(1);
        check("t6_q_rst", q, 4'b0000);
        check("t6_rise_rst", rise, 4'b0000);
        edges(1);
        @(negedge clk); reset = 1'b0;
        edges(9);
        check("t6_q_e9", q, 4'b0000);
        edges(1);
        check("t6_q_e10", q, 4'b0110);
        check("t6_rise", rise, 4'b0110);
        edges(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
